rf_bank_arbiter: RTL

RF_BANK_ARBITER -- requirements
Module: rf_bank_arbiter

---
 rtl/rf_bank_arbiter_if.sv | 32 +++
 rtl/rf_bank_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/rf_bank_arbiter_if.sv
// Register-file bank arbiter bus: per-slot read requests, CDB writeback,
// combinational grants and registered bank read/write controls.
interface rf_bank_arbiter_if;
    localparam int unsigned NSLOT  = 8;
    localparam int unsigned NBANK  = 4;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned SLOT_W = 3;

    logic [NSLOT-1:0]        req_valid;
    logic [NSLOT*BANK_W-1:0] req_bank;
    logic [NSLOT*ROW_W-1:0]  req_row;
    logic                    wr_valid;
    logic [BANK_W-1:0]       wr_bank;
    logic [ROW_W-1:0]        wr_row;
    logic [NSLOT-1:0]        req_grant;
    logic [NBANK-1:0]        rd_en;
    logic [NBANK*ROW_W-1:0]  rd_row;
    logic [NBANK*SLOT_W-1:0] rd_slot;
    logic [NBANK-1:0]        bank_wr_en;
    logic [ROW_W-1:0]        bank_wr_row;

    modport master (
        output req_valid, req_bank, req_row, wr_valid, wr_bank, wr_row,
        input  req_grant, rd_en, rd_row, rd_slot, bank_wr_en, bank_wr_row
    );

    modport slave (
        input  req_valid, req_bank, req_row, wr_valid, wr_bank, wr_row,
        output req_grant, rd_en, rd_row, rd_slot, bank_wr_en, bank_wr_row
    );
endinterface

// File: rtl/rf_bank_arbiter.sv
// Per-bank read-port arbiter for 8 operand slots over 4 RF banks with writeback priority.
// RF_ARB_ROUND_ROBIN_EN selects round-robin per bank; otherwise fixed lowest-index priority.
module rf_bank_arbiter (
    input logic              clk,
    input logic              rst,
    rf_bank_arbiter_if.slave bus
);
    localparam int unsigned NSLOT  = 8;
    localparam int unsigned NBANK  = 4;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned SLOT_W = 3;

    logic [NSLOT-1:0]        grant_c;
    logic                    found_c;
    logic [SLOT_W-1:0]       idx_c;
    logic [NBANK-1:0]        rd_en_d, rd_en_q;
    logic [NBANK*ROW_W-1:0]  rd_row_d, rd_row_q;
    logic [NBANK*SLOT_W-1:0] rd_slot_d, rd_slot_q;
    logic [NBANK-1:0]        bank_wr_en_d, bank_wr_en_q;
    logic [ROW_W-1:0]        bank_wr_row_d, bank_wr_row_q;
`ifdef RF_ARB_ROUND_ROBIN_EN
    logic [NBANK-1:0][SLOT_W-1:0] ptr_d, ptr_q;
`endif

    // Grant selection and next-state for read/write ports
    always_comb begin
        grant_c       = '0;
        found_c       = 1'b0;
        idx_c         = '0;
        rd_en_d       = '0;
        rd_row_d      = rd_row_q;
        rd_slot_d     = rd_slot_q;
        bank_wr_en_d  = '0;
        bank_wr_row_d = bank_wr_row_q;
`ifdef RF_ARB_ROUND_ROBIN_EN
        ptr_d         = ptr_q;
`endif
        if (bus.wr_valid) begin
            bank_wr_en_d[bus.wr_bank] = 1'b1;
            bank_wr_row_d             = bus.wr_row;
        end
        if (!rst) begin
            for (int unsigned b = 0; b < NBANK; b++) begin
                found_c = 1'b0;
                // A writeback owns the bank's port this cycle
                if (!(bus.wr_valid && (bus.wr_bank == BANK_W'(b)))) begin
                    for (int unsigned k = 0; k < NSLOT; k++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
                        idx_c = SLOT_W'(ptr_q[b] + SLOT_W'(k));
`else
                        idx_c = SLOT_W'(k);
`endif
                        if (!found_c && bus.req_valid[idx_c] &&
                            (bus.req_bank[BANK_W*idx_c +: BANK_W] == BANK_W'(b))) begin
                            found_c                     = 1'b1;
                            grant_c[idx_c]              = 1'b1;
                            rd_en_d[b]                  = 1'b1;
                            rd_row_d[ROW_W*b +: ROW_W]  = bus.req_row[ROW_W*idx_c +: ROW_W];
                            rd_slot_d[SLOT_W*b +: SLOT_W] = idx_c;
`ifdef RF_ARB_ROUND_ROBIN_EN
                            ptr_d[b]                    = SLOT_W'(idx_c + SLOT_W'(1));
`endif
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q       <= '0;
            rd_row_q      <= '0;
            rd_slot_q     <= '0;
            bank_wr_en_q  <= '0;
            bank_wr_row_q <= '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
            ptr_q         <= '0;
`endif
        end else begin
            rd_en_q       <= rd_en_d;
            rd_row_q      <= rd_row_d;
            rd_slot_q     <= rd_slot_d;
            bank_wr_en_q  <= bank_wr_en_d;
            bank_wr_row_q <= bank_wr_row_d;
`ifdef RF_ARB_ROUND_ROBIN_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign bus.req_grant   = grant_c;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_row      = rd_row_q;
    assign bus.rd_slot     = rd_slot_q;
    assign bus.bank_wr_en  = bank_wr_en_q;
    assign bus.bank_wr_row = bank_wr_row_q;
endmodule
